// File: rtl/reg_file_pkg.sv
// Shared definitions for the register file and its clear sequencer.
// The default widths are also used by the decode and writeback blocks.
package reg_file_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CLR  = 1'b1
  } clr_state_e;

endpackage

// File: rtl/reg_file_clear_seq.sv
// Sequential clear engine: walks every entry once, one per cycle, after
// RESET or a CLEAR command. A new RESET or CLEAR restarts the walk at 0.
module reg_file_clear_seq
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CLEAR,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;
  localparam logic [ADDR_W-1:0] IDX_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  clr_state_e        state_reg, state_next;
  logic [ADDR_W-1:0] idx_reg, idx_next;
  logic              busy_reg, busy_next;

  // Next-state logic; CLEAR restarts the walk from either state.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    busy_next  = busy_reg;
    case (state_reg)
      ST_IDLE: begin
        if (CLEAR) begin
          state_next = ST_CLR;
          idx_next   = '0;
          busy_next  = 1'b1;
        end
      end
      ST_CLR: begin
        if (CLEAR) begin
          idx_next = '0;
        end else if (idx_reg == LAST_IDX) begin
          state_next = ST_IDLE;
          idx_next   = '0;
          busy_next  = 1'b0;
        end else begin
          idx_next = idx_reg + IDX_ONE;
        end
      end
      default: begin
        state_next = ST_CLR;
        idx_next   = '0;
        busy_next  = 1'b1;
      end
    endcase
  end

  // State register; RESET parks the engine at index 0 without writing.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg <= ST_CLR;
      idx_reg   <= '0;
      busy_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      busy_reg  <= busy_next;
    end
  end

  // Storage is only zeroed on cycles where RESET is not asserted.
  assign clr_we   = (state_reg == ST_CLR) && !RESET;
  assign clr_addr = idx_reg;
  assign busy     = busy_reg;

endmodule

// File: rtl/reg_file_param.sv
// Parametrised register file: two combinational read ports, one write
// port, optional hardwired-zero entry 0 and optional write-to-read bypass.
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] INADDRESS,
  input  logic [DATA_W-1:0] IN,
  input  logic [ADDR_W-1:0] OUT1ADDRESS,
  input  logic [ADDR_W-1:0] OUT2ADDRESS,
  input  logic              CLEAR,
  output logic [DATA_W-1:0] OUT1,
  output logic [DATA_W-1:0] OUT2,
  output logic              BUSY,
  output logic              WR_DROP
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0]      mem [DEPTH];
  logic                   busy;
  logic                   clr_we;
  logic [ADDR_W-1:0]      clr_addr;
  logic                   zero_addr_wr;
  logic                   user_we;
  logic                   wr_drop_reg;
  logic [1:0][ADDR_W-1:0] rd_addr;

  reg_file_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .CLK      (CLK),
    .RESET    (RESET),
    .CLEAR    (CLEAR),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Writes to a hardwired-zero entry 0 vanish without being flagged.
  assign zero_addr_wr = (ZERO_REG != 0) && (INADDRESS == '0);
  assign user_we      = WRITE && !RESET && !busy && !CLEAR && !zero_addr_wr;

  // Storage write mux: the clear engine owns the port while busy.
  always_ff @(posedge CLK) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (user_we) begin
      mem[INADDRESS] <= IN;
    end
  end

  // Flag a write lost to a running or starting clear; RESET suppresses it.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_drop_reg <= 1'b0;
    end else begin
      wr_drop_reg <= WRITE && (busy || CLEAR) && !zero_addr_wr;
    end
  end

  assign rd_addr = {OUT2ADDRESS, OUT1ADDRESS};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
      logic [DATA_W-1:0] port_data;
      logic              bypass_hit;

      assign bypass_hit = (BYPASS != 0) && WRITE && (INADDRESS == rd_addr[gi]) && !zero_addr_wr;

      // Read mux: blank while clearing, zero entry, then bypass, then array.
      always_comb begin
        port_data = mem[rd_addr[gi]];
        if (busy) begin
          port_data = '0;
        end else if ((ZERO_REG != 0) && (rd_addr[gi] == '0)) begin
          port_data = '0;
        end else if (bypass_hit) begin
          port_data = IN;
        end
      end
    end
  endgenerate

  assign OUT1    = g_rd_port[0].port_data;
  assign OUT2    = g_rd_port[1].port_data;
  assign BUSY    = busy;
  assign WR_DROP = wr_drop_reg;

endmodule

// File: tb/tb_reg_file_param.sv
// Self-checking bench: directed scenarios followed by random traffic, both
// compared each cycle against an array-based reference model. Two DUTs run
// in lockstep, one with bypass enabled and one without.
module tb_reg_file_param;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic              clk = 1'b0;
  logic              RESET = 1'b0;
  logic              WRITE = 1'b0;
  logic              CLEAR = 1'b0;
  logic [ADDR_W-1:0] INADDRESS = '0;
  logic [DATA_W-1:0] IN = '0;
  logic [ADDR_W-1:0] OUT1ADDRESS = '0;
  logic [ADDR_W-1:0] OUT2ADDRESS = '0;
  logic [DATA_W-1:0] out1_b, out2_b, out1_nb, out2_nb;
  logic              busy_b, busy_nb, drop_b, drop_nb;

  always #5 clk = ~clk;

  reg_file_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1), .BYPASS(1)) dut (
    .CLK(clk), .RESET(RESET), .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS), .CLEAR(CLEAR),
    .OUT1(out1_b), .OUT2(out2_b), .BUSY(busy_b), .WR_DROP(drop_b)
  );

  reg_file_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .CLK(clk), .RESET(RESET), .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS), .CLEAR(CLEAR),
    .OUT1(out1_nb), .OUT2(out2_nb), .BUSY(busy_nb), .WR_DROP(drop_nb)
  );

  // Reference model: architectural contents plus remaining clear cycles.
  logic [DATA_W-1:0] m_mem [DEPTH];
  int                busy_left = 0;
  logic              exp_drop = 1'b0;
  bit                checking = 1'b0;
  int                total = 0;
  int                bad = 0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] exp_out(input logic [ADDR_W-1:0] a, input bit byp,
                                                 input logic wr, input logic [ADDR_W-1:0] wa,
                                                 input logic [DATA_W-1:0] d);
    if (busy_left > 0) return '0;
    if (a == 0) return '0;
    if (byp && wr && (a == wa)) return d;
    return m_mem[a];
  endfunction

  task automatic model_edge(input logic rst, input logic wr, input logic [ADDR_W-1:0] wa,
                            input logic [DATA_W-1:0] d, input logic clr);
    exp_drop = !rst && wr && ((busy_left > 0) || clr) && (wa != 0);
    if (rst || clr) begin
      busy_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    end else if (busy_left > 0) begin
      busy_left--;
    end else if (wr && (wa != 0)) begin
      m_mem[wa] = d;
    end
  endtask

  // One cycle: drive at the falling edge, check mid-cycle, advance the model.
  task automatic step(input logic rst, input logic wr, input logic [ADDR_W-1:0] wa,
                      input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] a1,
                      input logic [ADDR_W-1:0] a2, input logic clr);
    RESET = rst; WRITE = wr; INADDRESS = wa; IN = d;
    OUT1ADDRESS = a1; OUT2ADDRESS = a2; CLEAR = clr;
    #2;
    if (checking) begin
      chk("busy",     busy_b,  (busy_left > 0));
      chk("busy_nb",  busy_nb, (busy_left > 0));
      chk("wr_drop",  drop_b,  exp_drop);
      chk("wr_drop_nb", drop_nb, exp_drop);
      chk("out1",     out1_b,  exp_out(a1, 1'b1, wr, wa, d));
      chk("out2",     out2_b,  exp_out(a2, 1'b1, wr, wa, d));
      chk("out1_nb",  out1_nb, exp_out(a1, 1'b0, wr, wa, d));
      chk("out2_nb",  out2_nb, exp_out(a2, 1'b0, wr, wa, d));
    end
    $display("t=%0t rst=%0b clr=%0b wr=%0b wa=%0d d=%h a1=%0d a2=%0d out1=%h out2=%h out2_nb=%h busy=%0b drop=%0b",
             $time, rst, clr, wr, wa, d, a1, a2, out1_b, out2_b, out2_nb, busy_b, drop_b);
    @(posedge clk);
    model_edge(rst, wr, wa, d, clr);
    @(negedge clk);
    checking = 1'b1;
  endtask

  task automatic idle(input int n, input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, a1, a2, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    @(negedge clk);

    // 1: reset, full clear window, then write/read back
    step(1'b1, 1'b0, '0, '0, 5'd3, 5'd0, 1'b0);
    idle(DEPTH, 5'd3, 5'd7);
    step(1'b0, 1'b1, 5'd3, 32'hDEADBEEF, 5'd3, 5'd1, 1'b0);
    step(1'b0, 1'b0, '0, '0, 5'd3, 5'd3, 1'b0);

    // 2: same-cycle forwarding on port 2 (and its absence without bypass)
    step(1'b0, 1'b1, 5'd5, 32'h12345678, 5'd3, 5'd5, 1'b0);
    step(1'b0, 1'b0, '0, '0, 5'd5, 5'd5, 1'b0);

    // 3: writes to entry 0 are ignored and never flagged
    step(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b0);
    step(1'b0, 1'b0, '0, '0, 5'd0, 5'd0, 1'b0);

    // 4: write during a clear is dropped with a one-cycle flag
    step(1'b0, 1'b0, '0, '0, 5'd7, 5'd3, 1'b1);
    step(1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7, 1'b0);
    idle(DEPTH, 5'd7, 5'd3);
    step(1'b0, 1'b0, '0, '0, 5'd7, 5'd3, 1'b0);

    // 5: fill, clear, and restart via RESET partway through
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, i[4:0], i, 5'd1, 5'd2, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, '0, '0, i[4:0], 5'(DEPTH-1-i), 1'b0);
    step(1'b0, 1'b0, '0, '0, 5'd4, 5'd9, 1'b1);
    idle(10, 5'd4, 5'd9);
    step(1'b1, 1'b0, '0, '0, 5'd4, 5'd9, 1'b0);
    idle(DEPTH, 5'd4, 5'd9);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, '0, '0, i[4:0], 5'(DEPTH-1-i), 1'b0);

    // 6: write coincident with RESET is lost silently
    step(1'b1, 1'b1, 5'd9, 32'h1, 5'd9, 5'd9, 1'b0);
    idle(DEPTH, 5'd9, 5'd9);
    step(1'b0, 1'b0, '0, '0, 5'd9, 5'd9, 1'b0);

    // Random traffic with biased address collisions and rare clears/resets
    for (int n = 0; n < 800; n++) begin
      logic              r_rst, r_clr, r_wr;
      logic [ADDR_W-1:0] r_wa, r_a1, r_a2;
      logic [DATA_W-1:0] r_d;
      r_rst = ($urandom_range(0, 249) == 0);
      r_clr = ($urandom_range(0, 99) == 0);
      r_wr  = ($urandom_range(0, 2) != 0);
      r_wa  = ADDR_W'($urandom_range(0, DEPTH-1));
      r_d   = $urandom;
      r_a1  = ($urandom_range(0, 3) == 0) ? r_wa : ADDR_W'($urandom_range(0, DEPTH-1));
      r_a2  = ($urandom_range(0, 3) == 0) ? r_wa : ADDR_W'($urandom_range(0, DEPTH-1));
      step(r_rst, r_wr, r_wa, r_d, r_a1, r_a2, r_clr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
Parametrised multi-width register file for the RISC-V datapath, the successor to the fixed 8x8 register file.
- Two asynchronous read ports and one synchronous write port.
- Optional hardwired-zero entry 0 and optional write-to-read bypass.
- Clears storage with a sequential clear engine (one entry per cycle), not a wide single-cycle reset.
- Sits between decode (rs1/rs2/rd fields) and the ALU/writeback mux.

Parameters:
DATA_W, 32, width of each register and of IN/OUT1/OUT2
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes
BYPASS, 1, 1 = a write in the current cycle is forwarded combinationally to a matching read port

Ports:
CLK  input  1  clock, all state updates on rising edge
RESET  input  1  synchronous, active-high; starts a full clear
WRITE  input  1  write enable, sampled at rising edge
INADDRESS  input  ADDR_W  write address (rd)
IN  input  DATA_W  write data
OUT1ADDRESS  input  ADDR_W  read port 1 address (rs1)
OUT2ADDRESS  input  ADDR_W  read port 2 address (rs2)
CLEAR  input  1  synchronous command: re-clear all entries without reset
OUT1  output  DATA_W  read data port 1 (combinational)
OUT2  output  DATA_W  read data port 2 (combinational)
BUSY  output  1  registered; high while the clear engine runs
WR_DROP  output  1  registered one-cycle pulse: a write was discarded in the previous cycle

Behaviour:
- Clocking and reset: one clock, CLK. Reset RESET is synchronous and active-high.
- FSM states: IDLE, CLR. Registered index idx[ADDR_W-1:0].
- RESET=1 at an edge: state<=CLR, idx<=0, BUSY<=1, WR_DROP<=0. Storage is not touched in that cycle.
- Reset values: BUSY=1, WR_DROP=0. OUT1/OUT2 read 0 while BUSY=1.
- CLR, edge with RESET=0: mem[idx]<=0, idx<=idx+1. At idx==DEPTH-1: state<=IDLE, BUSY<=0.
  - BUSY therefore stays high exactly DEPTH cycles after RESET deasserts.
  - Holding RESET keeps idx at 0.
- IDLE, CLEAR=1: same transition as RESET (state<=CLR, idx<=0, BUSY<=1).
- CLEAR=1 while in CLR: restarts at idx 0 (restart semantics).
- RESET during CLR: restarts at idx 0; RESET has priority over CLEAR.
- Write, IDLE, WRITE=1, no CLEAR: mem[INADDRESS]<=IN at the edge. Visible on the read ports from the next cycle.
- Write while BUSY=1, or coincident with CLEAR: discarded, WR_DROP<=1 for one cycle.
- Write coincident with RESET: discarded, WR_DROP stays 0.
- ZERO_REG=1:
  - A write to address 0 is silently ignored; no WR_DROP.
  - A read of address 0 returns 0 regardless of BYPASS.
- Read path, BUSY=0:
  - OUTn = bypass_hit ? IN : mem[OUTnADDRESS].
  - bypass_hit = BYPASS && WRITE && INADDRESS==OUTnADDRESS && !(ZERO_REG && INADDRESS==0).
- Read path, BUSY=1: OUTn = 0, and bypass is disabled.
- Latency: read is 0 cycles (combinational). Write-to-read is 1 cycle, or 0 cycles with BYPASS.
- Both read ports may address the same entry; both return the same value.
- No internal # delays; timing is purely cycle-based.

Decomposition:
- Shared package reg_file_pkg holds:
  - FSM state encoding (ST_IDLE=1'b0, ST_CLR=1'b1);
  - default DATA_W/ADDR_W constants, shared with the decode and writeback blocks.
- One sub-module: reg_file_clear_seq.
  - Owns the FSM, idx, BUSY and the last-index detect.
  - Outputs clr_we/clr_addr into the storage write mux.
- Storage array, write arbitration, WR_DROP and read/bypass muxing stay in reg_file_param.

Test Plan:
1. RESET 1 cycle -> BUSY=1 for exactly 32 cycles with OUT1=OUT2=0. Then WRITE addr 3 = 0xDEADBEEF; next cycle OUT1ADDRESS=3 -> OUT1=0xDEADBEEF.
2. BYPASS=1: WRITE addr 5 = 0x12345678 with OUT2ADDRESS=5 in the same cycle -> OUT2=0x12345678 before the edge. With BYPASS=0 -> OUT2 shows the old value (0) until after the edge.
3. ZERO_REG=1: WRITE addr 0 = 0xFFFFFFFF with OUT1ADDRESS=0 -> OUT1=0 in the same and the next cycle; WR_DROP=0.
4. WRITE addr 7 = 0xA5A5A5A5 while BUSY=1 -> WR_DROP=1 for exactly one cycle. After clear completes, read addr 7 -> 0.
5. Fill all 32 entries with their index value, then CLEAR=1 -> BUSY 32 cycles, all entries read 0. Assert RESET when idx=10 -> BUSY extends 32 cycles past RESET release.
6. RESET=1 and WRITE=1 (addr 9 = 0x1) in the same cycle -> write lost, WR_DROP=0, addr 9 reads 0 after the clear.
